// File: rtl/keypad_pkg.sv
// Shared key codes, segment constants and slot-state type for the keypad entry/display slice.
// Combinational constants only: no latency, no flow control.
package keypad_pkg;
  localparam logic [3:0] KEY_STAR  = 4'd10;
  localparam logic [3:0] KEY_POUND = 4'd11;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_ZERO  = 8'hC0;
  localparam logic [2:0] MAX_DIG   = 3'd4;

  typedef enum logic {BLANK, ON} slot_st_t;
endpackage

// File: rtl/bcd_sseg_dec.sv
// BCD to active-low 7-segment {g,f,e,d,c,b,a}; codes 10-15 decode to blank.
// Purely combinational: zero latency, no backpressure.
module bcd_sseg_dec (
  input  logic [3:0] bcd,
  output logic [6:0] sseg
);
  always_comb begin
    sseg = 7'h7F;
    case (bcd)
      4'd0: sseg = 7'h40;
      4'd1: sseg = 7'h79;
      4'd2: sseg = 7'h24;
      4'd3: sseg = 7'h30;
      4'd4: sseg = 7'h19;
      4'd5: sseg = 7'h12;
      4'd6: sseg = 7'h02;
      4'd7: sseg = 7'h78;
      4'd8: sseg = 7'h00;
      4'd9: sseg = 7'h10;
      default: sseg = 7'h7F;
    endcase
  end
endmodule

// File: rtl/key_disp_sched.sv
// Keypad digit entry buffer plus 4-digit multiplexed 7-seg scan; seg/an one cycle behind state.
// No backpressure: every strobe is acted on the cycle it arrives, scan never stalls.
module key_disp_sched
  import keypad_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_CYC   = 16
) (
  input  logic        clk,
  input  logic        RST,
  input  logic [3:0]  KEY_VAL,
  input  logic        KEY_STB,
  input  logic        CLR,
  output logic [7:0]  seg,
  output logic [3:0]  an,
  output logic [15:0] DIGITS,
  output logic [2:0]  DIG_CNT,
  output logic        OVF
);
  localparam int PW = $clog2(REFRESH_DIV);

  logic [PW-1:0] presc;
  logic [1:0]    slot;
  slot_st_t      st;
  logic [3:0]    nib;
  logic [6:0]    sseg;
  logic          show;

  assign nib  = DIGITS[{slot, 2'b00} +: 4];
  assign show = ({1'b0, slot} < DIG_CNT);

  bcd_sseg_dec u_dec (
    .bcd  (nib),
    .sseg (sseg)
  );

  // CLR outranks any strobe in the same cycle, including a would-be overflow.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      DIGITS  <= 16'h0000;
      DIG_CNT <= 3'd0;
      OVF     <= 1'b0;
    end else begin
      OVF <= 1'b0;
      if (CLR) begin
        DIGITS  <= 16'h0000;
        DIG_CNT <= 3'd0;
      end else if (KEY_STB) begin
        if (KEY_VAL <= 4'd9) begin
          if (DIG_CNT < MAX_DIG) begin
            DIGITS  <= {DIGITS[11:0], KEY_VAL};
            DIG_CNT <= DIG_CNT + 3'd1;
          end else begin
            OVF <= 1'b1;
          end
        end else if (KEY_VAL == KEY_STAR) begin
          if (DIG_CNT != 3'd0) begin
            DIGITS  <= {4'h0, DIGITS[15:4]};
            DIG_CNT <= DIG_CNT - 3'd1;
          end
        end else if (KEY_VAL == KEY_POUND) begin
          DIGITS  <= 16'h0000;
          DIG_CNT <= 3'd0;
        end
      end
    end
  end

  // st tracks the phase of the current prescaler value; outputs follow it one cycle later.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      presc <= '0;
      slot  <= 2'd0;
      st    <= BLANK;
      an    <= 4'hF;
      seg   <= SEG_BLANK;
    end else begin
      if (presc == PW'(REFRESH_DIV - 1)) begin
        presc <= '0;
        slot  <= slot + 2'd1;
        st    <= BLANK;
      end else begin
        presc <= presc + PW'(1);
        if (presc == PW'(BLANK_CYC - 1))
          st <= ON;
      end

      if (st == BLANK) begin
        an  <= 4'hF;
        seg <= SEG_BLANK;
      end else begin
        an <= ~(4'b0001 << slot);
        if (show)
          seg <= {1'b1, sseg};
        else if (DIG_CNT == 3'd0 && slot == 2'd0)
          seg <= SEG_ZERO;
        else
          seg <= SEG_BLANK;
      end
    end
  end
endmodule

// File: tb/tb_key_disp_sched.sv
// Randomized bench for key_disp_sched with a queue-based entry model and time-based scan model.
module tb_key_disp_sched;
  localparam int RD = 8;
  localparam int BC = 2;

  logic        clk = 1'b0;
  logic        RST = 1'b1;
  logic [3:0]  KEY_VAL = 4'd0;
  logic        KEY_STB = 1'b0;
  logic        CLR = 1'b0;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic [15:0] DIGITS;
  logic [2:0]  DIG_CNT;
  logic        OVF;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  key_disp_sched #(.REFRESH_DIV(RD), .BLANK_CYC(BC)) dut (
    .clk     (clk),
    .RST     (RST),
    .KEY_VAL (KEY_VAL),
    .KEY_STB (KEY_STB),
    .CLR     (CLR),
    .seg     (seg),
    .an      (an),
    .DIGITS  (DIGITS),
    .DIG_CNT (DIG_CNT),
    .OVF     (OVF)
  );

  // Model: q[0] is the most recent digit; mn counts clocks since reset release.
  int         q[$];
  int         mn = 0;
  int         ph, sl;
  logic [7:0] e_seg = 8'hFF;
  logic [3:0] e_an = 4'hF;
  logic       e_ovf = 1'b0;
  bit         cmp_en = 1'b0;

  function automatic logic [7:0] seg_of(int d);
    string      s;
    logic [7:0] m;
    int         k;
    m = 8'hFF;
    case (d)
      0: s = "abcdef";
      1: s = "bc";
      2: s = "abdeg";
      3: s = "abcdg";
      4: s = "bcfg";
      5: s = "acdfg";
      6: s = "acdefg";
      7: s = "abc";
      8: s = "abcdefg";
      9: s = "abcdfg";
      default: s = "";
    endcase
    for (int i = 0; i < s.len(); i++) begin
      k = int'(s[i]) - 97;
      m[k] = 1'b0;
    end
    return m;
  endfunction

  function automatic logic [15:0] pack_q();
    logic [15:0] r;
    r = 16'h0;
    for (int i = 0; i < q.size(); i++) r[4*i +: 4] = 4'(q[i]);
    return r;
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  initial forever begin
    @(posedge clk or posedge RST);
    if (RST) begin
      q.delete();
      mn = 0;
      e_an = 4'hF;
      e_seg = 8'hFF;
      e_ovf = 1'b0;
    end else begin
      ph = mn % RD;
      sl = (mn / RD) % 4;
      if (ph < BC) begin
        e_an = 4'hF;
        e_seg = 8'hFF;
      end else begin
        e_an = 4'hF & ~(4'b0001 << sl);
        if (sl < q.size()) e_seg = seg_of(q[sl]);
        else if (q.size() == 0 && sl == 0) e_seg = seg_of(0);
        else e_seg = 8'hFF;
      end
      e_ovf = 1'b0;
      if (CLR) q.delete();
      else if (KEY_STB) begin
        if (KEY_VAL <= 4'd9) begin
          if (q.size() < 4) q.push_front(int'(KEY_VAL));
          else e_ovf = 1'b1;
        end else if (KEY_VAL == 4'd10) begin
          if (q.size() > 0) void'(q.pop_front());
        end else if (KEY_VAL == 4'd11) q.delete();
      end
      mn++;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("seg", seg, e_seg);
      check("an", an, e_an);
      check("digits", DIGITS, pack_q());
      check("dig_cnt", DIG_CNT, q.size());
      check("ovf", OVF, e_ovf);
      check("one_anode", ($countones(~an) <= 1), 1);
    end
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic key(logic [3:0] v, logic c);
    KEY_VAL = v;
    KEY_STB = 1'b1;
    CLR = c;
    step();
    KEY_STB = 1'b0;
    CLR = 1'b0;
  endtask

  task automatic capture(output logic [7:0] c0, output logic [7:0] c1,
                         output logic [7:0] c2, output logic [7:0] c3);
    c0 = 8'h00; c1 = 8'h00; c2 = 8'h00; c3 = 8'h00;
    for (int i = 0; i < 4 * RD * 2; i++) begin
      case (an)
        4'b1110: c0 = seg;
        4'b1101: c1 = seg;
        4'b1011: c2 = seg;
        4'b0111: c3 = seg;
        default: ;
      endcase
      step();
    end
  endtask

  logic [7:0] s0, s1, s2, s3;
  logic [3:0] prev_an;
  int         fcount;
  bit         found;

  initial begin
    repeat (2) step();
    check("rst_an", an, 4'hF);
    check("rst_seg", seg, 8'hFF);
    check("rst_digits", DIGITS, 16'h0);
    check("rst_cnt", DIG_CNT, 3'd0);
    check("rst_ovf", OVF, 1'b0);
    cmp_en = 1'b1;
    RST = 1'b0;

    key(4'd1, 1'b0); key(4'd2, 1'b0); key(4'd3, 1'b0); key(4'd4, 1'b0);
    check("fill_digits", DIGITS, 16'h1234);
    check("fill_cnt", DIG_CNT, 3'd4);
    capture(s0, s1, s2, s3);
    check("scan_slot0", s0, 8'h99);
    check("scan_slot1", s1, 8'hB0);
    check("scan_slot2", s2, 8'hA4);
    check("scan_slot3", s3, 8'hF9);

    key(4'd5, 1'b0);
    check("ovf_pulse", OVF, 1'b1);
    check("ovf_digits", DIGITS, 16'h1234);
    step();
    check("ovf_drop", OVF, 1'b0);

    key(4'd10, 1'b0); key(4'd10, 1'b0);
    check("bksp_digits", DIGITS, 16'h0012);
    check("bksp_cnt", DIG_CNT, 3'd2);
    capture(s0, s1, s2, s3);
    check("bksp_slot0", s0, 8'hA4);
    check("bksp_slot1", s1, 8'hF9);
    check("bksp_slot2", s2, 8'hFF);
    check("bksp_slot3", s3, 8'hFF);
    key(4'd10, 1'b0); key(4'd10, 1'b0); key(4'd10, 1'b0);
    check("bksp_empty_digits", DIGITS, 16'h0);
    check("bksp_empty_cnt", DIG_CNT, 3'd0);

    key(4'd5, 1'b0);
    key(4'd11, 1'b1);
    check("pound_clr_digits", DIGITS, 16'h0);
    key(4'd7, 1'b0);
    key(4'd7, 1'b1);
    check("clr_wins_digits", DIGITS, 16'h0);
    check("clr_wins_cnt", DIG_CNT, 3'd0);
    check("clr_wins_ovf", OVF, 1'b0);
    key(4'd3, 1'b0);
    key(4'd13, 1'b0);
    check("ignore_digits", DIGITS, 16'h0003);
    check("ignore_ovf", OVF, 1'b0);

    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (e_an == 4'b1011) found = 1'b1;
      else step();
    end
    check("find_slot2_on", found, 1'b1);
    RST = 1'b1;
    #1;
    check("mid_rst_an", an, 4'hF);
    check("mid_rst_seg", seg, 8'hFF);
    check("mid_rst_cnt", DIG_CNT, 3'd0);
    step();
    RST = 1'b0;
    step();
    check("rel_blank0_an", an, 4'hF);
    step();
    check("rel_blank1_an", an, 4'hF);
    step();
    check("rel_on_an", an, 4'b1110);
    check("rel_on_seg", seg, 8'hC0);

    for (int i = 0; i < 3000; i++) begin
      KEY_STB = ($urandom % 3 == 0);
      KEY_VAL = ($urandom % 4 == 0) ? 4'($urandom % 16) : 4'($urandom % 10);
      CLR = ($urandom % 40 == 0);
      RST = ($urandom % 500 == 0);
      step();
    end
    KEY_STB = 1'b0; CLR = 1'b0; RST = 1'b0;

    prev_an = an;
    fcount = -1;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (an == 4'hF) begin
        if (prev_an != 4'hF) fcount = 1;
        else if (fcount > 0) fcount++;
      end else if (prev_an == 4'hF && fcount > 0) begin
        check("blank_run", fcount, 2);
      end
      prev_an = an;
    end

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/key_disp_sched.md
KEY_DISP_SCHED -- requirements
Module: key_disp_sched

Interface
REQ-001 Parameter REFRESH_DIV, default 50000, clk cycles per digit slot (2 kHz digit rate at 100 MHz); SHALL be >= 4.
REQ-002 Parameter BLANK_CYC, default 16, all-anodes-off cycles at the start of each slot; SHALL be >= 1 and < REFRESH_DIV.
REQ-003 clk  in  1  system clock; all state on its rising edge.
REQ-004 RST  in  1  reset, asynchronous and active-high.
REQ-005 KEY_VAL  in  4  decoded key code from the keypad scanner (0-9 digits, 10 = '*', 11 = '#').
REQ-006 KEY_STB  in  1  one-cycle strobe, KEY_VAL valid.
REQ-007 CLR  in  1  synchronous clear request, level-sampled.
REQ-008 seg  out  8  cathodes, active-low, {dp,g,f,e,d,c,b,a}, registered.
REQ-009 an  out  4  anodes, active-low, an[0] = rightmost digit, registered.
REQ-010 DIGITS  out  16  entry buffer, 4 BCD nibbles, [3:0] = most recently entered digit.
REQ-011 DIG_CNT  out  3  number of valid digits, 0-4.
REQ-012 OVF  out  1  one-cycle pulse: digit key rejected because the buffer is full.

Function
REQ-013 KEY_STB with KEY_VAL 0-9 and DIG_CNT<4: DIGITS <= {DIGITS[11:0],KEY_VAL}, DIG_CNT+1, visible next cycle.
REQ-014 KEY_STB with KEY_VAL 0-9 and DIG_CNT==4: buffer unchanged; OVF=1 on the following cycle only.
REQ-015 KEY_STB with KEY_VAL 10 (backspace): if DIG_CNT>0, DIGITS <= {4'h0,DIGITS[15:4]}, DIG_CNT-1; if 0, no-op.
REQ-016 KEY_STB with KEY_VAL 11, or CLR=1: DIGITS=0, DIG_CNT=0.
REQ-017 KEY_STB with KEY_VAL 12-15: ignored, no OVF.
REQ-018 CLR and KEY_STB in the same cycle: CLR wins, key discarded, no OVF.
REQ-019 Prescaler counts 0..REFRESH_DIV-1, wraps to 0; on wrap, slot index advances 0->1->2->3->0.
REQ-020 Slot state machine per slot: BLANK (prescaler < BLANK_CYC, an=4'hF, seg=8'hFF) -> ON (remaining cycles, an = one-cold on slot index) -> BLANK of next slot.
REQ-021 ON, slot i < DIG_CNT: seg = 7-seg pattern of DIGITS[4i+3:4i]; dp (seg[7]) always 1.
REQ-022 ON, slot i >= DIG_CNT: digit blanked (seg=8'hFF, anode still driven); exception: DIG_CNT==0, slot 0 shows '0'.
REQ-023 seg/an registered: each reflects prescaler, slot and buffer state from the previous cycle (1-cycle latency).
REQ-024 Buffer updates mid-slot are displayed from the next cycle; scan timing is never reset or stalled by key activity.
REQ-025 BCD nibbles > 9 never occur in DIGITS; decoder SHALL output blank for 10-15 regardless.

Reset
REQ-026 RST=1 forces immediately: DIGITS=0, DIG_CNT=0, OVF=0, prescaler=0, slot=0, an=4'hF, seg=8'hFF.
REQ-027 First cycle after RST release begins BLANK of slot 0; a KEY_STB in that cycle is accepted normally.
REQ-028 RST mid-slot or mid-entry discards all state; no partial display pattern after release.

Structure
REQ-029 Package keypad_pkg: KEY_STAR=4'd10, KEY_POUND=4'd11, SEG_BLANK=8'hFF, SEG_ZERO, slot-state enum {BLANK,ON}.
REQ-030 One combinational sub-module bcd_sseg_dec (4-bit in, 7-bit active-low out); all sequencing in key_disp_sched.

Verification (REFRESH_DIV=8, BLANK_CYC=2)
REQ-031 RST pulse mid-ON of slot 2 -> an=4'hF, seg=8'hFF at once; DIG_CNT=0; after release slot 0 BLANK for 2 cycles, then an=4'b1110, seg='0'.
REQ-032 Strobe keys 1,2,3,4 -> DIGITS=16'h1234, DIG_CNT=4; over one 32-cycle scan an[0..3] show 4,3,2,1, each after 2 blank cycles.
REQ-033 With buffer full, strobe 5 -> OVF high exactly 1 cycle, DIGITS stays 16'h1234.
REQ-034 From 16'h1234 strobe 10 twice -> DIGITS=16'h0012, DIG_CNT=2; slots 2,3 blank; strobe 10 at DIG_CNT=0 -> no change.
REQ-035 Strobe 11 together with CLR=1, also 7 together with CLR=1 -> DIGITS=0, DIG_CNT=0, OVF=0; strobe 13 -> no change.
REQ-036 Continuous scan 1000 cycles -> exactly one anode low at a time, never two, with every ON-slot preceded by 2 cycles of an=4'hF.
